seg7_scan_driver: RTL and testbench

// Parametrised successor to the single-digit hex-to-7-segment top. Drives NDIGITS

---
 rtl/seg7_scan_if.sv | 31 +++
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// ============================================================================
// Module      : seg7_scan_if
// Description : Fabric-side bundle for the multiplexed 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_if #(
    parameter int NDIGITS = 3
) ();
    logic [4*NDIGITS-1:0] data_in;
    logic                 load;
    logic [NDIGITS-1:0]   digit_en;
    logic [NDIGITS-1:0]   blink_en;
    logic [6:0]           seg;
    logic [NDIGITS-1:0]   an;
    logic                 frame_done;
    logic                 heartbeat;

    modport master (
        output data_in, load, digit_en, blink_en,
        input  seg, an, frame_done, heartbeat
    );

    modport slave (
        input  data_in, load, digit_en, blink_en,
        output seg, an, frame_done, heartbeat
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed NDIGITS hex display driver with blanking,
//               per-digit enable/blink and a heartbeat output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int NDIGITS       = 3,
    parameter int REFRESH_DIV   = 20000,
    parameter int BLANK_CYCLES  = 100,
    parameter int BLINK_DIV     = 10000000,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    seg7_scan_if.slave bus
);

    localparam int c_SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [NDIGITS-1:0] c_AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};
    localparam logic [6:0] c_SEG_DARK = 7'h7F;

    if (NDIGITS < 1 || NDIGITS > 8) begin : g_bad_ndigits
        $error("seg7_scan_driver: NDIGITS must be 1..8");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
        $error("seg7_scan_driver: need 1 <= BLANK_CYCLES < REFRESH_DIV");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("seg7_scan_driver: BLINK_DIV must be >= 1");
    end

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    state_t                 r_state;
    logic [4*NDIGITS-1:0]   r_shadow;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_SLOT_W-1:0]    r_slot_cnt;
    logic [c_BLINK_W-1:0]   r_blink_cnt;
    logic                   r_heartbeat;
    logic                   r_frame_done;
    logic [6:0]             r_seg;
    logic [NDIGITS-1:0]     r_an;

    logic                   w_slot_wrap;
    logic                   w_blank_end;
    logic                   w_idx_last;
    logic                   w_lit;
    logic [3:0]             w_nib;
    logic [NDIGITS-1:0]     w_an_sel;

    // Active-high segment pattern, bit6..bit0; unknown input shows a lone dash.
    function automatic logic [6:0] f_enc(input logic [3:0] nib);
        case (nib)
            4'h0:    f_enc = 7'h7E;
            4'h1:    f_enc = 7'h48;
            4'h2:    f_enc = 7'h3D;
            4'h3:    f_enc = 7'h6D;
            4'h4:    f_enc = 7'h4B;
            4'h5:    f_enc = 7'h67;
            4'h6:    f_enc = 7'h77;
            4'h7:    f_enc = 7'h4C;
            4'h8:    f_enc = 7'h7F;
            4'h9:    f_enc = 7'h4F;
            4'hA:    f_enc = 7'h5F;
            4'hB:    f_enc = 7'h73;
            4'hC:    f_enc = 7'h31;
            4'hD:    f_enc = 7'h79;
            4'hE:    f_enc = 7'h37;
            4'hF:    f_enc = 7'h17;
            default: f_enc = 7'h01;
        endcase
    endfunction

    assign w_slot_wrap = (r_slot_cnt == c_SLOT_W'(REFRESH_DIV - 1));
    assign w_blank_end = (r_state == S_BLANK) &&
                         (r_slot_cnt == c_SLOT_W'(BLANK_CYCLES - 1));
    assign w_idx_last  = (r_idx == c_IDX_W'(NDIGITS - 1));

    // A load on the latch edge itself must still reach this slot, so bypass the shadow.
    assign w_nib    = bus.load ? bus.data_in[{r_idx, 2'b00} +: 4]
                               : r_shadow[{r_idx, 2'b00} +: 4];
    assign w_lit    = bus.digit_en[r_idx] & ~(bus.blink_en[r_idx] & ~r_heartbeat);
    assign w_an_sel = c_AN_OFF ^ (NDIGITS'(1) << r_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_BLANK;
            r_shadow     <= '0;
            r_idx        <= '0;
            r_slot_cnt   <= '0;
            r_blink_cnt  <= '0;
            r_heartbeat  <= 1'b0;
            r_frame_done <= 1'b0;
            r_seg        <= c_SEG_DARK;
            r_an         <= c_AN_OFF;
        end else begin
            if (bus.load) begin
                r_shadow <= bus.data_in;
            end

            if (r_blink_cnt == c_BLINK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_heartbeat <= ~r_heartbeat;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            if (w_slot_wrap) begin
                r_slot_cnt <= '0;
                r_idx      <= w_idx_last ? '0 : r_idx + 1'b1;
                r_state    <= S_BLANK;
                r_seg      <= c_SEG_DARK;
                r_an       <= c_AN_OFF;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
                if (w_blank_end) begin
                    r_state <= S_ON;
                    if (w_lit) begin
                        r_seg <= ~f_enc(w_nib);
                        r_an  <= w_an_sel;
                    end
                end
            end

            // Registered one cycle early so the pulse lines up with the final slot cycle.
            r_frame_done <= w_idx_last &&
                            (r_slot_cnt == c_SLOT_W'(REFRESH_DIV - 2));
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
    assign bus.heartbeat  = r_heartbeat;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;
    localparam int N  = 3;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int BD = 48;

    logic clk;
    logic reset;
    int   t;
    int   checks;
    int   errors;
    int   fd_count;

    logic [11:0] m_shadow;
    logic [6:0]  m_lat_seg;
    logic [2:0]  m_lat_an;
    logic [6:0]  enc_tbl [16];
    logic [6:0]  exp_seg;

    seg7_scan_if #(.NDIGITS(N)) bus ();

    seg7_scan_driver #(
        .NDIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B),
        .BLINK_DIV(BD), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Check cycle t against the model, absorb this cycle's inputs, advance one clock.
    task automatic step();
        int         pos;
        int         idx;
        int         hbv;
        logic [3:0] nib;
        logic       lit;
        pos = t % R;
        idx = (t / R) % N;
        hbv = (t / BD) % 2;
        check("seg", bus.seg, (pos < B) ? 7'h7F : m_lat_seg);
        check("an", bus.an, (pos < B) ? 3'b111 : m_lat_an);
        check("frame_done", bus.frame_done, (idx == N-1) && (pos == R-1));
        check("heartbeat", bus.heartbeat, hbv[0]);
        check("onehot", ($countones(~bus.an) <= 1), 1);
        if (bus.frame_done) fd_count++;
        if (pos == B-1) begin
            nib = bus.load ? bus.data_in[idx*4 +: 4] : m_shadow[idx*4 +: 4];
            lit = bus.digit_en[idx] && !(bus.blink_en[idx] && (hbv == 0));
            m_lat_seg = lit ? ~enc_tbl[nib] : 7'h7F;
            m_lat_an  = lit ? ~(3'b001 << idx) : 3'b111;
        end
        if (bus.load) m_shadow = bus.data_in;
        @(posedge clk);
        @(negedge clk);
        t++;
        bus.load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_pos(input int slot, input int pos);
        int k;
        k = 0;
        while (!(((t / R) % N == slot) && (t % R == pos)) && k < 4*N*R) begin
            step();
            k++;
        end
        if (k >= 4*N*R) check("wait_pos_timeout", 0, 1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset     = 1'b1;
        t         = 0;
        m_shadow  = '0;
        m_lat_seg = 7'h7F;
        m_lat_an  = 3'b111;
        bus.load  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_seg"}, bus.seg, 7'h7F);
        check({tag, "_an"}, bus.an, 3'b111);
        check({tag, "_fd"}, bus.frame_done, 1'b0);
        check({tag, "_hb"}, bus.heartbeat, 1'b0);
    endtask

    initial begin
        checks = 0; errors = 0; fd_count = 0; t = 0;
        enc_tbl = '{7'h7E, 7'h48, 7'h3D, 7'h6D, 7'h4B, 7'h67, 7'h77, 7'h4C,
                    7'h7F, 7'h4F, 7'h5F, 7'h73, 7'h31, 7'h79, 7'h37, 7'h17};
        reset        = 1'b0;
        bus.data_in  = '0;
        bus.load     = 1'b0;
        bus.digit_en = 3'b111;
        bus.blink_en = 3'b000;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        release_reset();

        // Basic scan of 2A5
        bus.data_in = 12'h2A5;
        bus.load    = 1'b1;
        wait_pos(0, 1);
        check("d0_blank_an", bus.an, 3'b111);
        wait_pos(0, 3);
        check("d0_seg", bus.seg, 7'h18);
        check("d0_an", bus.an, 3'b110);
        wait_pos(1, 3);
        check("d1_seg", bus.seg, 7'h20);
        check("d1_an", bus.an, 3'b101);
        wait_pos(2, 3);
        check("d2_seg", bus.seg, 7'h42);
        check("d2_an", bus.an, 3'b011);

        // Frame pulse rate
        wait_pos(0, 0);
        fd_count = 0;
        run(96);
        check("fd_count", fd_count, 4);

        // Digit enable
        bus.digit_en = 3'b101;
        wait_pos(1, 4);
        check("d1_off_an", bus.an, 3'b111);
        check("d1_off_seg", bus.seg, 7'h7F);
        run(48);
        bus.digit_en = 3'b111;

        // Blink on digit 0 across two heartbeat periods
        bus.blink_en = 3'b001;
        run(192);
        bus.blink_en = 3'b000;

        // Mid-ON load does not alter the lit digit
        bus.data_in = 12'h2A5;
        bus.load    = 1'b1;
        wait_pos(0, 6);
        bus.data_in = 12'h000;
        bus.load    = 1'b1;
        step();
        check("midon_seg", bus.seg, 7'h18);
        wait_pos(0, 3);
        check("nextframe_seg", bus.seg, 7'h01);

        // Nibble sweep on digit 0, loaded in its last blank cycle
        for (int n = 0; n < 16; n++) begin
            wait_pos(0, 1);
            bus.data_in = {8'h5C, 4'(n)};
            bus.load    = 1'b1;
            wait_pos(0, 3);
            exp_seg = ~enc_tbl[n];
            check("sweep_seg", bus.seg, exp_seg);
        end

        // Randomized traffic
        repeat (600) begin
            bus.data_in  = 12'($urandom);
            bus.load     = ($urandom % 4) == 0;
            bus.digit_en = 3'($urandom);
            bus.blink_en = 3'($urandom);
            step();
        end

        // Reset mid-frame
        bus.digit_en = 3'b111;
        bus.blink_en = 3'b000;
        wait_pos(1, 5);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_vals("midrst");
        release_reset();
        wait_pos(0, 1);
        check("rst_blank_an", bus.an, 3'b111);
        step();
        check("rst_d0_an", bus.an, 3'b110);
        check("rst_d0_seg", bus.seg, 7'h01);
        run(48);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
